// File: rtl/icache_responder.sv
// Direct-mapped instruction cache returning two fetch words per request, with blocking line fills.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_INSTRUCTION
`define SIZE_INSTRUCTION 32
`endif

module icache_responder #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [`SIZE_PC-1:0]          PC_i,
  input  logic [`SIZE_PC-1:0]          PCadd1_i,
  input  logic                         req_i,
  output logic [`SIZE_INSTRUCTION-1:0] instruction0_o,
  output logic [`SIZE_INSTRUCTION-1:0] instruction1_o,
  output logic                         instValid_o,
  output logic                         stall_o,
  output logic                         memReq_o,
  output logic [`SIZE_PC-1:0]          memAddr_o,
  input  logic                         memGrant_i,
  input  logic                         memValid_i,
  input  logic [`SIZE_INSTRUCTION-1:0] memData_i,
  output logic [15:0]                  hitCount_o,
  output logic [15:0]                  missCount_o
);
  localparam int PW = `SIZE_PC;
  localparam int DW = `SIZE_INSTRUCTION;
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(NUM_LINES);
  localparam int LW = PW - OW;
  localparam int TW = LW - IW;
  localparam int AW = IW + OW;

  typedef enum logic [2:0] {IDLE, REQ0, FILL0, REQ1, FILL1, RESP} state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [DW-1:0]        data_q [NUM_LINES*WORDS_PER_LINE];
  logic [LW-1:0]        fill_line_q, fill_line_d;
  logic [OW-1:0]        beat_q, beat_d;
  logic [DW-1:0]        word0_q, word0_d;
  logic [DW-1:0]        instr0_q, instr0_d, instr1_q, instr1_d;
  logic                 inst_valid_q, inst_valid_d;
  logic                 stall_q, stall_d;
  logic                 mem_req_q, mem_req_d;

  logic [LW-1:0] line0_s, line1_s;
  logic [IW-1:0] idx0_s, idx1_s, fill_idx_s;
  logic [AW-1:0] addr0_s, addr1_s, wr_addr_s;
  logic          hit0_s, hit1_s, wr_en_s, last_s, miss1_after_s;
  logic [DW-1:0] rd0_s, rd1_s;

  assign line0_s    = PC_i[PW-1:OW];
  assign line1_s    = PCadd1_i[PW-1:OW];
  assign idx0_s     = line0_s[IW-1:0];
  assign idx1_s     = line1_s[IW-1:0];
  assign addr0_s    = PC_i[AW-1:0];
  assign addr1_s    = PCadd1_i[AW-1:0];
  assign hit0_s     = valid_q[idx0_s] && (tag_q[idx0_s] == line0_s[LW-1:IW]);
  assign hit1_s     = valid_q[idx1_s] && (tag_q[idx1_s] == line1_s[LW-1:IW]);
  assign fill_idx_s = fill_line_q[IW-1:0];
  assign wr_addr_s  = {fill_idx_s, beat_q};
  assign wr_en_s    = ((state_q == FILL0) || (state_q == FILL1)) && memValid_i;
  assign last_s     = wr_en_s && (beat_q == OW'(WORDS_PER_LINE - 1));
  // The word being written this cycle is forwarded so completion can respond without a re-read.
  assign rd0_s      = (wr_en_s && (wr_addr_s == addr0_s)) ? memData_i : data_q[addr0_s];
  assign rd1_s      = (wr_en_s && (wr_addr_s == addr1_s)) ? memData_i : data_q[addr1_s];
  // A same-index second line is evicted by the first fill, so it must be fetched as well.
  assign miss1_after_s = (line1_s != line0_s) && ((idx1_s == idx0_s) || !hit1_s);

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    fill_line_d  = fill_line_q;
    beat_d       = beat_q;
    word0_d      = word0_q;
    instr0_d     = instr0_q;
    instr1_d     = instr1_q;
    inst_valid_d = 1'b0;
    stall_d      = stall_q;
    mem_req_d    = mem_req_q;
    case (state_q)
      IDLE: begin
        if (req_i && !hit0_s) begin
          state_d     = REQ0;
          stall_d     = 1'b1;
          mem_req_d   = 1'b1;
          fill_line_d = line0_s;
        end else if (req_i && !hit1_s) begin
          state_d     = REQ1;
          stall_d     = 1'b1;
          mem_req_d   = 1'b1;
          fill_line_d = line1_s;
          word0_d     = rd0_s;
        end else if (req_i) begin
          inst_valid_d = 1'b1;
          instr0_d     = rd0_s;
          instr1_d     = rd1_s;
        end else begin
          state_d = IDLE;
        end
      end
      REQ0, REQ1: begin
        if (memGrant_i) begin
          state_d   = (state_q == REQ0) ? FILL0 : FILL1;
          mem_req_d = 1'b0;
          beat_d    = '0;
        end else begin
          state_d = state_q;
        end
      end
      FILL0, FILL1: begin
        if (wr_en_s) begin
          beat_d = beat_q + OW'(1);
        end else begin
          beat_d = beat_q;
        end
        if (last_s) begin
          valid_d[fill_idx_s] = 1'b1;
          if ((state_q == FILL0) && miss1_after_s) begin
            state_d     = REQ1;
            mem_req_d   = 1'b1;
            fill_line_d = line1_s;
            word0_d     = rd0_s;
          end else begin
            state_d      = RESP;
            stall_d      = 1'b0;
            inst_valid_d = 1'b1;
            instr0_d     = (state_q == FILL0) ? rd0_s : word0_q;
            instr1_d     = rd1_s;
          end
        end else begin
          state_d = state_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        stall_d   = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Control state, valid bits and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      fill_line_q  <= '0;
      beat_q       <= '0;
      word0_q      <= '0;
      instr0_q     <= '0;
      instr1_q     <= '0;
      inst_valid_q <= 1'b0;
      stall_q      <= 1'b0;
      mem_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      fill_line_q  <= fill_line_d;
      beat_q       <= beat_d;
      word0_q      <= word0_d;
      instr0_q     <= instr0_d;
      instr1_q     <= instr1_d;
      inst_valid_q <= inst_valid_d;
      stall_q      <= stall_d;
      mem_req_q    <= mem_req_d;
    end
  end

  // Data and tag storage; contents are qualified by valid_q so need no reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      data_q[wr_addr_s] <= memData_i;
    end
    if (last_s) begin
      tag_q[fill_idx_s] <= fill_line_q[LW-1:IW];
    end
  end

  assign instruction0_o = instr0_q;
  assign instruction1_o = instr1_q;
  assign instValid_o    = inst_valid_q;
  assign stall_o        = stall_q;
  assign memReq_o       = mem_req_q;
  assign memAddr_o      = {fill_line_q, {OW{1'b0}}};

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        hit_evt_s, miss_evt_s;

  assign hit_evt_s  = (state_q == IDLE) && req_i && hit0_s && hit1_s;
  assign miss_evt_s = (state_q == IDLE) && req_i && !(hit0_s && hit1_s);

  // Saturating statistics update
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_evt_s && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
    if (miss_evt_s && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hitCount_o  = hit_cnt_q;
  assign missCount_o = miss_cnt_q;
`else
  assign hitCount_o  = 16'd0;
  assign missCount_o = 16'd0;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Randomized self-checking bench for icache_responder against a line-level cache model.
`timescale 1ns/1ps
module tb_icache_responder;
  localparam int NL  = 16;
  localparam int WPL = 4;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC_i = '0, PCadd1_i = '0;
  logic        req_i = 1'b0;
  logic [31:0] instruction0_o, instruction1_o;
  logic        instValid_o, stall_o, memReq_o;
  logic [31:0] memAddr_o;
  logic        memGrant_i = 1'b0, memValid_i = 1'b0;
  logic [31:0] memData_i = '0;
  logic [15:0] hitCount_o, missCount_o;

  int checks = 0;
  int failures = 0;

  bit          m_valid [NL];
  int unsigned m_tag   [NL];
  int          m_hits, m_misses;

  icache_responder #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .reset(reset), .PC_i(PC_i), .PCadd1_i(PCadd1_i), .req_i(req_i),
    .instruction0_o(instruction0_o), .instruction1_o(instruction1_o),
    .instValid_o(instValid_o), .stall_o(stall_o), .memReq_o(memReq_o),
    .memAddr_o(memAddr_o), .memGrant_i(memGrant_i), .memValid_i(memValid_i),
    .memData_i(memData_i), .hitCount_o(hitCount_o), .missCount_o(missCount_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h60;
  endfunction

  function automatic bit m_hit(input int unsigned line);
    return m_valid[line % NL] && (m_tag[line % NL] == line / NL);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endtask

  // Expected fills of one request: each missing line once, in PC order, against the updated cache.
  task automatic m_predict(input logic [31:0] pc0, input logic [31:0] pc1,
                           output int nf, output logic [31:0] f0, output logic [31:0] f1);
    int unsigned l0, l1;
    logic [31:0] fl [2];
    l0 = pc0 / WPL;
    l1 = pc1 / WPL;
    nf = 0;
    fl[0] = '0;
    fl[1] = '0;
    if (!m_hit(l0)) begin
      fl[nf] = l0 * WPL; nf++;
      m_valid[l0 % NL] = 1'b1; m_tag[l0 % NL] = l0 / NL;
    end
    if (!m_hit(l1)) begin
      fl[nf] = l1 * WPL; nf++;
      m_valid[l1 % NL] = 1'b1; m_tag[l1 % NL] = l1 / NL;
    end
    if (nf == 0) m_hits++; else m_misses++;
    f0 = fl[0];
    f1 = fl[1];
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    req_i = 1'b0; memGrant_i = 1'b0; memValid_i = 1'b0;
    m_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drives one fetch request and acts as memory; records what it observed, no judging here.
  task automatic issue(input logic [31:0] pc0, input logic [31:0] pc1, input int gdelay,
                       input int gap_pct, output int nf, output logic [31:0] fa0,
                       output logic [31:0] fa1, output logic [31:0] r0, output logic [31:0] r1,
                       output int lat, output bit stall_bad, output bit addr_bad, output bit tmo);
    bit in_req, filling;
    int reqcnt, beat;
    logic [31:0] held;
    nf = 0; fa0 = '0; fa1 = '0; r0 = '0; r1 = '0; lat = 0;
    stall_bad = 1'b0; addr_bad = 1'b0; tmo = 1'b1;
    in_req = 1'b0; filling = 1'b0; reqcnt = 0; beat = 0; held = '0;
    @(negedge clk);
    PC_i = pc0; PCadd1_i = pc1; req_i = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (memGrant_i) begin filling = 1'b1; beat = 0; in_req = 1'b0; end
      else if (filling && memValid_i) begin
        beat++;
        if (beat == WPL) filling = 1'b0;
      end
      memGrant_i = 1'b0;
      memValid_i = 1'b0;
      if (instValid_o) begin
        r0 = instruction0_o; r1 = instruction1_o; lat = cyc;
        if (stall_o) stall_bad = 1'b1;
        tmo = 1'b0;
        break;
      end
      if (!stall_o) stall_bad = 1'b1;
      if (memReq_o) begin
        if (!in_req) begin
          in_req = 1'b1; reqcnt = 0; held = memAddr_o;
          if (nf == 0) fa0 = memAddr_o; else fa1 = memAddr_o;
          nf++;
        end else if (memAddr_o !== held) addr_bad = 1'b1;
        if (reqcnt >= gdelay) memGrant_i = 1'b1;
        reqcnt++;
        memValid_i = ($urandom_range(0, 3) == 0);
        memData_i  = 32'hDEADBEEF;
      end else if (filling) begin
        memValid_i = ($urandom_range(0, 99) >= gap_pct);
        memData_i  = memValid_i ? mem_word(held + beat) : $urandom();
      end
    end
    req_i = 1'b0; memGrant_i = 1'b0; memValid_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (instValid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instValid_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
    checks++; if (memReq_o !== 1'b0) begin failures++; $display("FAIL rst_memreq got=%b exp=0", memReq_o); end
    checks++; if (memAddr_o !== 32'h0) begin failures++; $display("FAIL rst_memaddr got=%h exp=0", memAddr_o); end
    checks++; if (instruction0_o !== 32'h0) begin failures++; $display("FAIL rst_i0 got=%h exp=0", instruction0_o); end
    checks++; if (instruction1_o !== 32'h0) begin failures++; $display("FAIL rst_i1 got=%h exp=0", instruction1_o); end
    checks++; if (hitCount_o !== 16'h0) begin failures++; $display("FAIL rst_hits got=%0d exp=0", hitCount_o); end
    checks++; if (missCount_o !== 16'h0) begin failures++; $display("FAIL rst_misses got=%0d exp=0", missCount_o); end
    reset = 1'b1;
    m_clear();
  endtask

  task automatic test_cold_and_hit();
    int nf, enf, lat; logic [31:0] fa0, fa1, ef0, ef1, r0, r1; bit sb, ab, tmo;
    m_predict(32'h40, 32'h41, enf, ef0, ef1);
    issue(32'h40, 32'h41, 0, 0, nf, fa0, fa1, r0, r1, lat, sb, ab, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL cold_timeout got=1 exp=0"); end
    checks++; if (nf !== 1) begin failures++; $display("FAIL cold_nfills got=%0d exp=1", nf); end
    checks++; if (fa0 !== 32'h40) begin failures++; $display("FAIL cold_addr got=%h exp=40", fa0); end
    checks++; if (r0 !== 32'hA0) begin failures++; $display("FAIL cold_i0 got=%h exp=a0", r0); end
    checks++; if (r1 !== 32'hA1) begin failures++; $display("FAIL cold_i1 got=%h exp=a1", r1); end
    checks++; if (sb !== 1'b0) begin failures++; $display("FAIL cold_stall got=1 exp=0"); end
    m_predict(32'h40, 32'h41, enf, ef0, ef1);
    issue(32'h40, 32'h41, 0, 0, nf, fa0, fa1, r0, r1, lat, sb, ab, tmo);
    checks++; if (lat !== 1) begin failures++; $display("FAIL hit_latency got=%0d exp=1", lat); end
    checks++; if (nf !== 0) begin failures++; $display("FAIL hit_nfills got=%0d exp=0", nf); end
    checks++; if ({r0, r1} !== {32'hA0, 32'hA1}) begin failures++; $display("FAIL hit_words got=%h %h exp=a0 a1", r0, r1); end
    checks++; if (sb !== 1'b0) begin failures++; $display("FAIL hit_stall got=1 exp=0"); end
    checks++; if (hitCount_o !== (STATS ? 16'(m_hits) : 16'd0)) begin failures++; $display("FAIL hit_count got=%0d exp=%0d", hitCount_o, STATS ? m_hits : 0); end
  endtask

  task automatic test_cross_line();
    int nf, enf, lat; logic [31:0] fa0, fa1, ef0, ef1, r0, r1; bit sb, ab, tmo;
    reset_dut();
    m_predict(32'h43, 32'h44, enf, ef0, ef1);
    issue(32'h43, 32'h44, 1, 20, nf, fa0, fa1, r0, r1, lat, sb, ab, tmo);
    checks++; if (nf !== 2) begin failures++; $display("FAIL cross_nfills got=%0d exp=2", nf); end
    checks++; if ({fa0, fa1} !== {32'h40, 32'h44}) begin failures++; $display("FAIL cross_addrs got=%h %h exp=40 44", fa0, fa1); end
    checks++; if ({r0, r1} !== {32'hA3, 32'hA4}) begin failures++; $display("FAIL cross_words got=%h %h exp=a3 a4", r0, r1); end
  endtask

  task automatic test_grant_gaps();
    int nf, enf, lat; logic [31:0] fa0, fa1, ef0, ef1, r0, r1; bit sb, ab, tmo;
    m_predict(32'h80, 32'h81, enf, ef0, ef1);
    issue(32'h80, 32'h81, 5, 60, nf, fa0, fa1, r0, r1, lat, sb, ab, tmo);
    checks++; if (ab !== 1'b0) begin failures++; $display("FAIL gap_addr_stable got=unstable exp=stable"); end
    checks++; if (fa0 !== 32'h80) begin failures++; $display("FAIL gap_addr got=%h exp=80", fa0); end
    checks++; if ({r0, r1} !== {mem_word(32'h80), mem_word(32'h81)}) begin failures++; $display("FAIL gap_words01 got=%h %h", r0, r1); end
    m_predict(32'h82, 32'h83, enf, ef0, ef1);
    issue(32'h82, 32'h83, 0, 0, nf, fa0, fa1, r0, r1, lat, sb, ab, tmo);
    checks++; if ({nf, r0, r1} !== {32'd0, mem_word(32'h82), mem_word(32'h83)}) begin failures++; $display("FAIL gap_words23 got=n%0d %h %h", nf, r0, r1); end
  endtask

  task automatic test_reset_mid_fill();
    int nf, enf, lat; logic [31:0] fa0, fa1, ef0, ef1, r0, r1; bit sb, ab, tmo;
    @(negedge clk);
    PC_i = 32'hC0; PCadd1_i = 32'hC1; req_i = 1'b1;
    @(negedge clk);
    checks++; if (memReq_o !== 1'b1) begin failures++; $display("FAIL midrst_req got=%b exp=1", memReq_o); end
    memGrant_i = 1'b1;
    @(negedge clk);
    memGrant_i = 1'b0; memValid_i = 1'b1; memData_i = mem_word(32'hC0);
    @(negedge clk);
    memData_i = mem_word(32'hC1);
    @(negedge clk);
    memValid_i = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++; if ({instValid_o, stall_o, memReq_o} !== 3'b000) begin failures++; $display("FAIL midrst_ctrl got=%b exp=000", {instValid_o, stall_o, memReq_o}); end
    checks++; if ({memAddr_o, instruction0_o, instruction1_o} !== 96'h0) begin failures++; $display("FAIL midrst_data got=%h %h %h exp=0", memAddr_o, instruction0_o, instruction1_o); end
    checks++; if ({hitCount_o, missCount_o} !== 32'h0) begin failures++; $display("FAIL midrst_counts got=%0d %0d exp=0", hitCount_o, missCount_o); end
    req_i = 1'b0;
    m_clear();
    @(negedge clk);
    reset = 1'b1;
    m_predict(32'hC0, 32'hC1, enf, ef0, ef1);
    issue(32'hC0, 32'hC1, 0, 0, nf, fa0, fa1, r0, r1, lat, sb, ab, tmo);
    checks++; if ({nf, fa0} !== {32'd1, 32'hC0}) begin failures++; $display("FAIL midrst_refill got=n%0d %h exp=n1 c0", nf, fa0); end
    checks++; if ({r0, r1} !== {mem_word(32'hC0), mem_word(32'hC1)}) begin failures++; $display("FAIL midrst_words got=%h %h", r0, r1); end
  endtask

  task automatic test_index_wrap();
    int nf, enf, lat; logic [31:0] fa0, fa1, ef0, ef1, r0, r1; bit sb, ab, tmo;
    reset_dut();
    m_predict(32'h3F, 32'h40, enf, ef0, ef1);
    issue(32'h3F, 32'h40, 0, 10, nf, fa0, fa1, r0, r1, lat, sb, ab, tmo);
    checks++; if ({nf, fa0, fa1} !== {32'd2, 32'h3C, 32'h40}) begin failures++; $display("FAIL wrap_fills got=n%0d %h %h exp=n2 3c 40", nf, fa0, fa1); end
    checks++; if ({r0, r1} !== {32'h9F, 32'hA0}) begin failures++; $display("FAIL wrap_words got=%h %h exp=9f a0", r0, r1); end
    checks++; if (missCount_o !== (STATS ? 16'(m_misses) : 16'd0)) begin failures++; $display("FAIL wrap_misses got=%0d exp=%0d", missCount_o, STATS ? m_misses : 0); end
  endtask

  task automatic test_evict();
    int nf, enf, lat; logic [31:0] fa0, fa1, ef0, ef1, r0, r1; bit sb, ab, tmo;
    for (int k = 0; k < 2; k++) begin
      m_predict(32'h101, 32'h142, enf, ef0, ef1);
      issue(32'h101, 32'h142, 0, 0, nf, fa0, fa1, r0, r1, lat, sb, ab, tmo);
      checks++; if ({nf, fa0, fa1} !== {enf, ef0, ef1}) begin failures++; $display("FAIL evict_fills%0d got=n%0d %h %h exp=n%0d %h %h", k, nf, fa0, fa1, enf, ef0, ef1); end
      checks++; if ({r0, r1} !== {mem_word(32'h101), mem_word(32'h142)}) begin failures++; $display("FAIL evict_words%0d got=%h %h", k, r0, r1); end
    end
  endtask

  task automatic test_random();
    int nf, enf, lat; logic [31:0] fa0, fa1, ef0, ef1, r0, r1, pc0, pc1; bit sb, ab, tmo;
    for (int n = 0; n < 60; n++) begin
      pc0 = $urandom_range(0, 511);
      case ($urandom_range(0, 3))
        0:       pc1 = pc0 + 32'd64 * $urandom_range(1, 3);
        1:       pc1 = $urandom_range(0, 511);
        default: pc1 = pc0 + 32'd1;
      endcase
      m_predict(pc0, pc1, enf, ef0, ef1);
      issue(pc0, pc1, $urandom_range(0, 3), $urandom_range(0, 50), nf, fa0, fa1, r0, r1, lat, sb, ab, tmo);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL rnd_timeout n=%0d", n); end
      checks++; if ({nf, fa0, fa1} !== {enf, ef0, ef1}) begin failures++; $display("FAIL rnd_fills n=%0d got=n%0d %h %h exp=n%0d %h %h", n, nf, fa0, fa1, enf, ef0, ef1); end
      checks++; if ({r0, r1} !== {mem_word(pc0), mem_word(pc1)}) begin failures++; $display("FAIL rnd_words n=%0d got=%h %h exp=%h %h", n, r0, r1, mem_word(pc0), mem_word(pc1)); end
      checks++; if ({sb, ab} !== 2'b00) begin failures++; $display("FAIL rnd_handshake n=%0d got stall_bad=%b addr_bad=%b exp=0 0", n, sb, ab); end
      if (enf == 0) begin
        checks++; if (lat !== 1) begin failures++; $display("FAIL rnd_hit_latency n=%0d got=%0d exp=1", n, lat); end
      end
    end
    @(negedge clk);
    checks++; if (hitCount_o !== (STATS ? 16'(m_hits) : 16'd0)) begin failures++; $display("FAIL rnd_hits got=%0d exp=%0d", hitCount_o, STATS ? m_hits : 0); end
    checks++; if (missCount_o !== (STATS ? 16'(m_misses) : 16'd0)) begin failures++; $display("FAIL rnd_misses got=%0d exp=%0d", missCount_o, STATS ? m_misses : 0); end
  endtask

  initial begin
    test_reset();
    test_cold_and_hit();
    test_cross_line();
    test_grant_gaps();
    test_reset_mid_fill();
    test_index_wrap();
    test_evict();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
